// File: rtl/ps2_key_decoder_pkg.sv
// Shared key codes, PS/2 scancodes and frame FSM types for the PS/2 key decoder.
// Key codes match the ones the game state machine expects on its key input.
package ps2_key_decoder_pkg;

    localparam logic [1:0] KEY_NONE  = 2'b00;
    localparam logic [1:0] KEY_LEFT  = 2'b01;
    localparam logic [1:0] KEY_RIGHT = 2'b10;
    localparam logic [1:0] KEY_START = 2'b11;

    localparam logic [7:0] PS2_E0   = 8'hE0;
    localparam logic [7:0] PS2_F0   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_t;

    typedef struct packed {
        logic       mapped;
        logic [1:0] code;
    } key_map_t;

    // Left/right arrows only exist in the extended (E0) set; space only in the base set.
    function automatic key_map_t map_scancode(input logic ext, input logic [7:0] sc);
        key_map_t m;
        m.mapped = 1'b1;
        m.code   = KEY_NONE;
        if (ext && sc == SC_LEFT)
            m.code = KEY_LEFT;
        else if (ext && sc == SC_RIGHT)
            m.code = KEY_RIGHT;
        else if (!ext && sc == SC_SPACE)
            m.code = KEY_START;
        else
            m.mapped = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 pin inputs and decoded key outputs of the key decoder.
// The decoder uses the slave view; whoever drives the pins uses the master view.
interface ps2_key_decoder_if;
    logic       PS2Clk;
    logic       PS2Data;
    logic [1:0] key;
    logic       key_strobe;
    logic       frame_err;

    modport slave (
        input  PS2Clk,
        input  PS2Data,
        output key,
        output key_strobe,
        output frame_err
    );

    modport master (
        output PS2Clk,
        output PS2Data,
        input  key,
        input  key_strobe,
        input  frame_err
    );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: pin synchronisers, PS2Clk fall detect, 11-bit frame FSM and
// inter-bit timeout. Emits one byte_valid pulse per good frame, frame_err on bad ones.
module ps2_rx_frame
    import ps2_key_decoder_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int             TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TO_MAX = TW'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic [TW-1:0]          r_to_cnt;
    frame_state_t           r_state;
    frame_state_t           w_state_nxt;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par_ok;
    logic                   r_byte_valid;
    logic                   r_frame_err;

    logic w_fall;
    logic w_bit;
    logic w_timeout;
    logic w_start;
    logic w_shift_en;
    logic w_par_cap;
    logic w_byte_ok;
    logic w_err;

    // Idle-high line: preload the synchronisers with 1 so reset never fakes a fall.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_bit  = r_data_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_to_cnt <= '0;
        else if (w_fall)
            r_to_cnt <= '0;
        else if (r_to_cnt != TO_MAX)
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    // A fall in the same cycle as expiry wins: the bit is taken and the count restarts.
    assign w_timeout = (r_to_cnt == TO_MAX) && (r_state != FR_IDLE) && !w_fall;

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_state <= FR_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_par_cap   = 1'b0;
        w_byte_ok   = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            FR_IDLE: begin
                if (w_fall && !w_bit) begin
                    w_start     = 1'b1;
                    w_state_nxt = FR_DATA;
                end
            end
            FR_DATA: begin
                if (w_fall) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7)
                        w_state_nxt = FR_PARITY;
                end
            end
            FR_PARITY: begin
                if (w_fall) begin
                    w_par_cap   = 1'b1;
                    w_state_nxt = FR_STOP;
                end
            end
            FR_STOP: begin
                if (w_fall) begin
                    w_state_nxt = FR_IDLE;
                    if (w_bit && r_par_ok)
                        w_byte_ok = 1'b1;
                    else
                        w_err = 1'b1;
                end
            end
            default: w_state_nxt = FR_IDLE;
        endcase
        if (w_timeout)
            w_state_nxt = FR_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_ok     <= 1'b0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= w_byte_ok;
            r_frame_err  <= w_err;
            if (w_start)
                r_bit_cnt <= '0;
            if (w_shift_en) begin
                r_shift   <= {w_bit, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            // Odd parity across the 8 data bits plus the parity bit.
            if (w_par_cap)
                r_par_ok <= ^{r_shift, w_bit};
        end
    end

    assign o_byte       = r_shift;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to 2-bit game key: tracks E0/F0 prefixes and the currently held key,
// pulsing key_strobe whenever the held key changes.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    ps2_key_decoder_if.slave bus
);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_frame_err;
    key_map_t   w_map;

    logic       r_ext;
    logic       r_brk;
    logic [1:0] r_key;
    logic       r_key_strobe;

    ps2_rx_frame #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ps2_clk    (bus.PS2Clk),
        .i_ps2_data   (bus.PS2Data),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    assign w_map = map_scancode(r_ext, w_byte);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_key        <= KEY_NONE;
            r_key_strobe <= 1'b0;
        end else begin
            r_key_strobe <= 1'b0;
            if (w_frame_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_byte_valid) begin
                if (w_byte == PS2_E0) begin
                    r_ext <= 1'b1;
                end else if (w_byte == PS2_F0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    // Make: last pressed wins, repeats are silent. Break: only releases the held key.
                    if (w_map.mapped && !r_brk && w_map.code != r_key) begin
                        r_key        <= w_map.code;
                        r_key_strobe <= 1'b1;
                    end else if (w_map.mapped && r_brk && w_map.code == r_key) begin
                        r_key        <= KEY_NONE;
                        r_key_strobe <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.key        = r_key;
    assign bus.key_strobe = r_key_strobe;
    assign bus.frame_err  = w_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of scancode sequences with expected key
// and strobe counts, plus hand-written parity/stop error, timeout and mid-frame reset cases.
module tb_ps2_key_decoder;

    localparam int SYNC = 2;
    localparam int TO   = 300;
    localparam int H    = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   strobe_cnt = 0;
    int   err_cnt = 0;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bus.key_strobe) strobe_cnt++;
        if (bus.frame_err)  err_cnt++;
    end

    typedef struct {
        logic [23:0] seq;
        int          n;
        logic [1:0]  exp_key;
        int          exp_strb;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.PS2Data = f[i];
            repeat (H/2) @(posedge clk);
            bus.PS2Clk = 1'b0;
            repeat (H) @(posedge clk);
            bus.PS2Clk = 1'b1;
            repeat (H/2) @(posedge clk);
        end
        bus.PS2Data = 1'b1;
        repeat (H) @(posedge clk);
    endtask

    task automatic send_seq(input logic [23:0] seq, input int n);
        for (int k = 0; k < n; k++)
            send_frame(seq[23-8*k -: 8], 1'b0, 1'b0, 11);
    endtask

    task automatic settle();
        repeat (SYNC + 8) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int s0, e0;
        vecs[0]  = '{{8'h29, 16'h0},        1, 2'b11, 1};
        vecs[1]  = '{{8'hF0, 8'h29, 8'h0},  2, 2'b00, 1};
        vecs[2]  = '{{8'hE0, 8'h6B, 8'h0},  2, 2'b01, 1};
        vecs[3]  = '{{8'hE0, 8'hF0, 8'h6B}, 3, 2'b00, 1};
        vecs[4]  = '{{8'hE0, 8'h6B, 8'h0},  2, 2'b01, 1};
        vecs[5]  = '{{8'hE0, 8'h74, 8'h0},  2, 2'b10, 1};
        vecs[6]  = '{{8'hE0, 8'hF0, 8'h6B}, 3, 2'b10, 0};
        vecs[7]  = '{{8'hE0, 8'h74, 8'h0},  2, 2'b10, 0};
        vecs[8]  = '{{8'h6B, 16'h0},        1, 2'b10, 0};
        vecs[9]  = '{{8'hE0, 8'h29, 8'h0},  2, 2'b10, 0};
        vecs[10] = '{{8'hE0, 8'hF0, 8'h74}, 3, 2'b00, 1};
        vecs[11] = '{{8'h29, 16'h0},        1, 2'b11, 1};
        vecs[12] = '{{8'h29, 16'h0},        1, 2'b11, 0};
        vecs[13] = '{{8'hE0, 8'h6B, 8'h0},  2, 2'b01, 1};
        vecs[14] = '{{8'hF0, 8'h29, 8'h0},  2, 2'b01, 0};
        vecs[15] = '{{8'hE0, 8'hF0, 8'h6B}, 3, 2'b00, 1};

        bus.PS2Clk  = 1'b1;
        bus.PS2Data = 1'b1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_key", int'(bus.key), 0);
        check("reset_strobe", int'(bus.key_strobe), 0);
        check("reset_frame_err", int'(bus.frame_err), 0);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        for (int v = 0; v < 16; v++) begin
            s0 = strobe_cnt;
            e0 = err_cnt;
            send_seq(vecs[v].seq, vecs[v].n);
            settle();
            check($sformatf("vec%0d_key", v), int'(bus.key), int'(vecs[v].exp_key));
            check($sformatf("vec%0d_strobes", v), strobe_cnt - s0, vecs[v].exp_strb);
            check($sformatf("vec%0d_frame_err", v), err_cnt - e0, 0);
        end

        // Bad parity: error pulse, key untouched, then a good extended make lands.
        s0 = strobe_cnt; e0 = err_cnt;
        send_frame(8'h29, 1'b1, 1'b0, 11);
        settle();
        check("badpar_err", err_cnt - e0, 1);
        check("badpar_key", int'(bus.key), 0);
        check("badpar_strobes", strobe_cnt - s0, 0);
        send_seq({8'hE0, 8'h74, 8'h0}, 2);
        settle();
        check("after_badpar_key", int'(bus.key), 2);

        // Error frame must clear a pending E0, so the following 6B is unmapped.
        s0 = strobe_cnt; e0 = err_cnt;
        send_frame(8'hE0, 1'b0, 1'b0, 11);
        send_frame(8'h29, 1'b0, 1'b1, 11);
        send_frame(8'h6B, 1'b0, 1'b0, 11);
        settle();
        check("badstop_err", err_cnt - e0, 1);
        check("badstop_clears_ext_key", int'(bus.key), 2);
        check("badstop_strobes", strobe_cnt - s0, 0);

        // Partial frame then silence past the timeout; next full frame decodes cleanly.
        s0 = strobe_cnt; e0 = err_cnt;
        send_frame(8'h29, 1'b0, 1'b0, 5);
        repeat (TO + 50) @(posedge clk);
        send_frame(8'h29, 1'b0, 1'b0, 11);
        settle();
        check("timeout_key", int'(bus.key), 3);
        check("timeout_err", err_cnt - e0, 0);
        check("timeout_strobes", strobe_cnt - s0, 1);

        // Reset in the middle of a frame discards it.
        send_frame(8'hE0, 1'b0, 1'b0, 6);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset_key", int'(bus.key), 0);
        check("midreset_frame_err", int'(bus.frame_err), 0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        s0 = strobe_cnt; e0 = err_cnt;
        send_seq({8'hE0, 8'h74, 8'h0}, 2);
        settle();
        check("after_reset_key", int'(bus.key), 2);
        check("after_reset_strobes", strobe_cnt - s0, 1);
        check("after_reset_err", err_cnt - e0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
